// File: rtl/rx_cmd_decoder.sv
// Decodes UART RX bytes into register-write/read and ALU operand/function command strobes.
// Latency 1 cycle from an input strobe to Out/Err strobes; the input is never stalled, one byte per cycle.
module rx_cmd_decoder #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    NUM_OPERANDS   = 2,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] CMD_RF_WR      = DATA_WIDTH'('hAA),
    parameter logic [DATA_WIDTH-1:0] CMD_RF_RD      = DATA_WIDTH'('hBB),
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP     = DATA_WIDTH'('hCC),
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP    = DATA_WIDTH'('hDD)
) (
    input  logic                  RXDec_CLK,
    input  logic                  RXDec_RST,
    input  logic [DATA_WIDTH-1:0] RXDec_In_Data,
    input  logic                  RXDec_In_Valid,
    input  logic                  RXDec_In_Err,
    output logic [DATA_WIDTH-1:0] RXDec_Out_Data,
    output logic [ADDR_WIDTH-1:0] RXDec_Out_Addr,
    output logic [2:0]            RXDec_Out_Command,
    output logic                  RXDec_Out_Valid,
    output logic                  RXDec_Err_Valid,
    output logic [1:0]            RXDec_Err_Code,
    output logic                  RXDec_Busy
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] OP_LAST = ADDR_WIDTH'(NUM_OPERANDS - 1);

    localparam logic [2:0] OC_WR  = 3'b001;
    localparam logic [2:0] OC_RD  = 3'b010;
    localparam logic [2:0] OC_OPR = 3'b011;
    localparam logic [2:0] OC_FUN = 3'b100;

    localparam logic [1:0] EC_ILLEGAL = 2'b01;
    localparam logic [1:0] EC_TIMEOUT = 2'b10;
    localparam logic [1:0] EC_BYTE    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_OPER,
        S_FUN
    } state_t;

    state_t                  r_state;
    state_t                  w_nxt_state;
    logic                    r_cmd_rd;
    logic                    w_nxt_cmd_rd;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]   w_nxt_addr;
    logic [ADDR_WIDTH-1:0]   r_op_cnt;
    logic [ADDR_WIDTH-1:0]   w_nxt_op_cnt;
    logic [TW-1:0]           r_idle_cnt;

    logic                    w_byte_ok;
    logic                    w_byte_bad;
    logic                    w_expire;
    logic                    w_out_vld;
    logic [2:0]              w_out_cmd;
    logic [ADDR_WIDTH-1:0]   w_out_addr;
    logic [DATA_WIDTH-1:0]   w_out_dat;
    logic                    w_err_vld;
    logic [1:0]              w_err_code;

    assign w_byte_ok  = RXDec_In_Valid & ~RXDec_In_Err;
    assign w_byte_bad = RXDec_In_Valid & RXDec_In_Err;

    // Expire on the cycle the counter would reach the limit, so a byte in that same cycle still wins.
    assign w_expire = TO_EN && (r_state != S_IDLE) && !RXDec_In_Valid && (r_idle_cnt == TO_LAST);

    always_ff @(posedge RXDec_CLK or posedge RXDec_RST) begin
        if (RXDec_RST) begin
            r_state  <= S_IDLE;
            r_cmd_rd <= 1'b0;
            r_addr   <= '0;
            r_op_cnt <= '0;
        end else begin
            r_state  <= w_nxt_state;
            r_cmd_rd <= w_nxt_cmd_rd;
            r_addr   <= w_nxt_addr;
            r_op_cnt <= w_nxt_op_cnt;
        end
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_cmd_rd = r_cmd_rd;
        w_nxt_addr   = r_addr;
        w_nxt_op_cnt = r_op_cnt;
        w_out_vld    = 1'b0;
        w_out_cmd    = 3'b000;
        w_out_addr   = '0;
        w_out_dat    = '0;
        w_err_vld    = 1'b0;
        w_err_code   = 2'b00;

        if (w_byte_bad) begin
            w_err_vld   = 1'b1;
            w_err_code  = EC_BYTE;
            w_nxt_state = S_IDLE;
        end else if (w_byte_ok) begin
            case (r_state)
                S_IDLE: begin
                    if (RXDec_In_Data == CMD_RF_WR) begin
                        w_nxt_cmd_rd = 1'b0;
                        w_nxt_state  = S_ADDR;
                    end else if (RXDec_In_Data == CMD_RF_RD) begin
                        w_nxt_cmd_rd = 1'b1;
                        w_nxt_state  = S_ADDR;
                    end else if (RXDec_In_Data == CMD_ALU_OP) begin
                        w_nxt_op_cnt = '0;
                        w_nxt_state  = S_OPER;
                    end else if (RXDec_In_Data == CMD_ALU_NOP) begin
                        w_nxt_state  = S_FUN;
                    end else begin
                        w_err_vld    = 1'b1;
                        w_err_code   = EC_ILLEGAL;
                    end
                end
                S_ADDR: begin
                    w_nxt_addr = RXDec_In_Data[ADDR_WIDTH-1:0];
                    if (r_cmd_rd) begin
                        w_out_vld   = 1'b1;
                        w_out_cmd   = OC_RD;
                        w_out_addr  = RXDec_In_Data[ADDR_WIDTH-1:0];
                        w_nxt_state = S_IDLE;
                    end else begin
                        w_nxt_state = S_DATA;
                    end
                end
                S_DATA: begin
                    w_out_vld   = 1'b1;
                    w_out_cmd   = OC_WR;
                    w_out_addr  = r_addr;
                    w_out_dat   = RXDec_In_Data;
                    w_nxt_state = S_IDLE;
                end
                S_OPER: begin
                    w_out_vld  = 1'b1;
                    w_out_cmd  = OC_OPR;
                    w_out_addr = r_op_cnt;
                    w_out_dat  = RXDec_In_Data;
                    if (r_op_cnt == OP_LAST) begin
                        w_nxt_state = S_FUN;
                    end else begin
                        w_nxt_op_cnt = r_op_cnt + 1'b1;
                    end
                end
                S_FUN: begin
                    w_out_vld   = 1'b1;
                    w_out_cmd   = OC_FUN;
                    w_out_dat   = RXDec_In_Data;
                    w_nxt_state = S_IDLE;
                end
                default: w_nxt_state = S_IDLE;
            endcase
        end else if (w_expire) begin
            w_err_vld   = 1'b1;
            w_err_code  = EC_TIMEOUT;
            w_nxt_state = S_IDLE;
        end
    end

    // Cleared in IDLE, on frame entry and on any input strobe; otherwise counts silent frame cycles.
    always_ff @(posedge RXDec_CLK or posedge RXDec_RST) begin
        if (RXDec_RST) begin
            r_idle_cnt <= '0;
        end else if (r_state == S_IDLE || w_nxt_state == S_IDLE || RXDec_In_Valid) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge RXDec_CLK or posedge RXDec_RST) begin
        if (RXDec_RST) begin
            RXDec_Out_Valid   <= 1'b0;
            RXDec_Out_Command <= 3'b000;
            RXDec_Out_Addr    <= '0;
            RXDec_Out_Data    <= '0;
            RXDec_Err_Valid   <= 1'b0;
            RXDec_Err_Code    <= 2'b00;
            RXDec_Busy        <= 1'b0;
        end else begin
            RXDec_Out_Valid   <= w_out_vld;
            RXDec_Out_Command <= w_out_cmd;
            RXDec_Out_Addr    <= w_out_addr;
            RXDec_Out_Data    <= w_out_dat;
            RXDec_Err_Valid   <= w_err_vld;
            RXDec_Err_Code    <= w_err_code;
            RXDec_Busy        <= (w_nxt_state != S_IDLE);
        end
    end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Directed bench for rx_cmd_decoder: instance a uses 2 operands, instance b uses 3; both time out after 16 idle cycles.
module tb_rx_cmd_decoder;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_err;
    logic       vld_a;
    logic       vld_b;

    logic [7:0] a_dat, b_dat;
    logic [7:0] a_addr, b_addr;
    logic [2:0] a_cmd, b_cmd;
    logic       a_ov, b_ov;
    logic       a_ev, b_ev;
    logic [1:0] a_ec, b_ec;
    logic       a_busy, b_busy;

    int tests = 0;
    int fails = 0;

    rx_cmd_decoder #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_OPERANDS(2), .TIMEOUT_CYCLES(16)
    ) dut_a (
        .RXDec_CLK(clk), .RXDec_RST(rst),
        .RXDec_In_Data(in_data), .RXDec_In_Valid(vld_a), .RXDec_In_Err(in_err),
        .RXDec_Out_Data(a_dat), .RXDec_Out_Addr(a_addr), .RXDec_Out_Command(a_cmd),
        .RXDec_Out_Valid(a_ov), .RXDec_Err_Valid(a_ev), .RXDec_Err_Code(a_ec),
        .RXDec_Busy(a_busy)
    );

    rx_cmd_decoder #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_OPERANDS(3), .TIMEOUT_CYCLES(16)
    ) dut_b (
        .RXDec_CLK(clk), .RXDec_RST(rst),
        .RXDec_In_Data(in_data), .RXDec_In_Valid(vld_b), .RXDec_In_Err(in_err),
        .RXDec_Out_Data(b_dat), .RXDec_Out_Addr(b_addr), .RXDec_Out_Command(b_cmd),
        .RXDec_Out_Valid(b_ov), .RXDec_Err_Valid(b_ev), .RXDec_Err_Code(b_ec),
        .RXDec_Busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of input at a falling edge; outputs then reflect the previous cycle's input.
    task automatic cyc(input logic [7:0] d, input logic va, input logic vb, input logic e);
        @(negedge clk);
        in_data = d;
        vld_a   = va;
        vld_b   = vb;
        in_err  = e;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_data = 8'h00; in_err = 1'b0; vld_a = 1'b0; vld_b = 1'b0;
        idle(2);
        chk("rst_out_a", {12'h0, a_ov, a_cmd, a_addr, a_dat}, 32'h0);
        chk("rst_err_busy_a", {29'h0, a_ev, a_ec}, 32'h0);
        chk("rst_busy", {30'h0, a_busy, b_busy}, 32'h0);
        @(negedge clk); rst = 1'b0;

        // Write frame
        cyc(8'hAA, 1, 0, 0);
        cyc(8'h05, 1, 0, 0);
        chk("wr_busy", {31'h0, a_busy}, 32'h1);
        cyc(8'h3C, 1, 0, 0);
        chk("wr_none_yet", {12'h0, a_ov, a_cmd, a_addr, a_dat}, 32'h0);
        idle(1);
        chk("wr_out", {12'h0, a_ov, a_cmd, a_addr, a_dat}, {12'h0, 1'b1, 3'b001, 8'h05, 8'h3C});
        idle(1);
        chk("wr_single", {31'h0, a_ov}, 32'h0);
        chk("wr_busy_after", {31'h0, a_busy}, 32'h0);

        // Read frame followed back-to-back by ALU_NOP frame
        cyc(8'hBB, 1, 0, 0);
        cyc(8'h12, 1, 0, 0);
        cyc(8'hDD, 1, 0, 0);
        chk("rd_out", {12'h0, a_ov, a_cmd, a_addr, a_dat}, {12'h0, 1'b1, 3'b010, 8'h12, 8'h00});
        cyc(8'h07, 1, 0, 0);
        chk("nop_cmd_quiet", {31'h0, a_ov}, 32'h0);
        idle(1);
        chk("nop_out", {12'h0, a_ov, a_cmd, a_addr, a_dat}, {12'h0, 1'b1, 3'b100, 8'h00, 8'h07});

        // ALU_OP, two operands
        cyc(8'hCC, 1, 0, 0);
        cyc(8'h11, 1, 0, 0);
        cyc(8'h22, 1, 0, 0);
        chk("op2_0", {12'h0, a_ov, a_cmd, a_addr, a_dat}, {12'h0, 1'b1, 3'b011, 8'h00, 8'h11});
        cyc(8'h03, 1, 0, 0);
        chk("op2_1", {12'h0, a_ov, a_cmd, a_addr, a_dat}, {12'h0, 1'b1, 3'b011, 8'h01, 8'h22});
        idle(1);
        chk("op2_fun", {12'h0, a_ov, a_cmd, a_addr, a_dat}, {12'h0, 1'b1, 3'b100, 8'h00, 8'h03});
        idle(1);
        chk("op2_done", {30'h0, a_ov, a_busy}, 32'h0);

        // ALU_OP, three operands on instance b
        cyc(8'hCC, 0, 1, 0);
        cyc(8'h11, 0, 1, 0);
        cyc(8'h22, 0, 1, 0);
        chk("op3_0", {12'h0, b_ov, b_cmd, b_addr, b_dat}, {12'h0, 1'b1, 3'b011, 8'h00, 8'h11});
        cyc(8'h33, 0, 1, 0);
        chk("op3_1", {12'h0, b_ov, b_cmd, b_addr, b_dat}, {12'h0, 1'b1, 3'b011, 8'h01, 8'h22});
        cyc(8'h04, 0, 1, 0);
        chk("op3_2", {12'h0, b_ov, b_cmd, b_addr, b_dat}, {12'h0, 1'b1, 3'b011, 8'h02, 8'h33});
        idle(1);
        chk("op3_fun", {12'h0, b_ov, b_cmd, b_addr, b_dat}, {12'h0, 1'b1, 3'b100, 8'h00, 8'h04});
        idle(1);
        chk("op3_done", {28'h0, b_ov, b_ev, b_ec[0], b_busy}, 32'h0);
        chk("op3_errcode", {30'h0, b_ec}, 32'h0);

        // Illegal command, then a clean write frame
        cyc(8'h5A, 1, 0, 0);
        idle(1);
        chk("ill_err", {29'h0, a_ev, a_ec}, {29'h0, 1'b1, 2'b01});
        chk("ill_quiet", {30'h0, a_ov, a_busy}, 32'h0);
        cyc(8'hAA, 1, 0, 0);
        chk("ill_err_clear", {29'h0, a_ev, a_ec}, 32'h0);
        cyc(8'h01, 1, 0, 0);
        cyc(8'hFF, 1, 0, 0);
        idle(1);
        chk("ill_wr_out", {12'h0, a_ov, a_cmd, a_addr, a_dat}, {12'h0, 1'b1, 3'b001, 8'h01, 8'hFF});

        // Timeout: AA,05 then silence
        cyc(8'hAA, 1, 0, 0);
        cyc(8'h05, 1, 0, 0);
        idle(16);
        chk("to_not_yet", {29'h0, a_ev, a_busy, 1'b0}, {29'h0, 1'b0, 1'b1, 1'b0});
        idle(1);
        chk("to_err", {29'h0, a_ev, a_ec}, {29'h0, 1'b1, 2'b10});
        chk("to_busy_drop", {31'h0, a_busy}, 32'h0);
        idle(1);
        chk("to_single", {29'h0, a_ev, a_ec}, 32'h0);

        // Byte on the 16th idle cycle restarts the count
        cyc(8'hCC, 1, 0, 0);
        cyc(8'h11, 1, 0, 0);
        idle(15);
        cyc(8'h22, 1, 0, 0);
        chk("to_edge_no_err", {31'h0, a_ev}, 32'h0);
        idle(1);
        chk("to_edge_byte", {12'h0, a_ov, a_cmd, a_addr, a_dat}, {12'h0, 1'b1, 3'b011, 8'h01, 8'h22});
        chk("to_edge_state", {30'h0, a_ev, a_busy}, 32'h1);
        idle(15);
        chk("to_restart_quiet", {30'h0, a_ev, a_busy}, 32'h1);
        idle(1);
        chk("to_restart_err", {29'h0, a_ev, a_ec}, {29'h0, 1'b1, 2'b10});

        // Byte error mid-frame and in IDLE
        cyc(8'hCC, 1, 0, 0);
        cyc(8'h11, 1, 0, 0);
        cyc(8'h77, 1, 0, 1);
        idle(1);
        chk("be_err", {29'h0, a_ev, a_ec}, {29'h0, 1'b1, 2'b11});
        chk("be_abort", {30'h0, a_ov, a_busy}, 32'h0);
        cyc(8'h03, 1, 0, 0);
        chk("be_no_fun", {31'h0, a_ov}, 32'h0);
        idle(1);
        chk("be_then_illegal", {28'h0, a_ov, a_ev, a_ec}, {28'h0, 1'b0, 1'b1, 2'b01});
        cyc(8'hAA, 1, 0, 1);
        idle(1);
        chk("be_idle_err", {29'h0, a_ev, a_ec}, {29'h0, 1'b1, 2'b11});
        chk("be_idle_busy", {31'h0, a_busy}, 32'h0);

        // Reset mid-frame
        cyc(8'hAA, 1, 0, 0);
        idle(1);
        chk("rm_busy", {31'h0, a_busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rm_out", {12'h0, a_ov, a_cmd, a_addr, a_dat}, 32'h0);
        chk("rm_err_busy", {29'h0, a_ev, a_ec[1], a_busy}, 32'h0);
        idle(1);
        rst = 1'b0;
        cyc(8'hAA, 1, 0, 0);
        cyc(8'h01, 1, 0, 0);
        cyc(8'h02, 1, 0, 0);
        idle(1);
        chk("rm_wr_out", {12'h0, a_ov, a_cmd, a_addr, a_dat}, {12'h0, 1'b1, 3'b001, 8'h01, 8'h02});
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
